// File: rtl/sipo.sv
// Serial-in, parallel-out shift register with a frame counter, a registered
// frame output, a one-cycle latch-enable strobe and a cascading serial output.
module sipo #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CW       = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] out,
    output logic             le,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    always_comb begin
        sr_next = sr;
        if (MSB_FIRST != 0) begin
            sr_next = {sr[WIDTH-2:0], sin};
        end else begin
            sr_next = {sin, sr[WIDTH-1:1]};
        end
    end

    assign sout     = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign count    = cnt;

    // The frame register captures sr_next so the completing bit is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
            out <= '0;
            le  <= 1'b0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
            le  <= 1'b0;
        end else if (en) begin
            sr <= sr_next;
            if (last_bit) begin
                cnt <= '0;
                out <= sr_next;
                le  <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
                le  <= 1'b0;
            end
        end else begin
            le <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: an 8-bit MSB-first and a 5-bit LSB-first
// instance share one stimulus stream and are compared against a bit-history model.
module tb_sipo;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       en;
    logic       sin;

    logic       sout_a;
    logic [7:0] out_a;
    logic       le_a;
    logic [2:0] count_a;

    logic       sout_b;
    logic [4:0] out_b;
    logic       le_b;
    logic [2:0] count_b;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 0;

    // Model state per instance: k=0 is WIDTH=8/MSB_FIRST=1, k=1 is WIDTH=5/MSB_FIRST=0.
    // hist[k][0] is the most recently shifted bit since the last clear.
    int mw   [2] = '{8, 5};
    int mmsb [2] = '{1, 0};
    int hist [2][8];
    int mcnt [2];
    int mout [2];
    int mle  [2];

    sipo #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .sin(sin),
        .sout(sout_a), .out(out_a), .le(le_a), .count(count_a)
    );

    sipo #(.WIDTH(5), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .sin(sin),
        .sout(sout_b), .out(out_b), .le(le_b), .count(count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) hist[k][i] = 0;
                mcnt[k] = 0;
                mout[k] = 0;
                mle[k]  = 0;
            end else if (clr) begin
                for (int i = 0; i < 8; i++) hist[k][i] = 0;
                mcnt[k] = 0;
                mle[k]  = 0;
            end else if (en) begin
                for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = int'(sin);
                mcnt[k]++;
                mle[k] = 0;
                if (mcnt[k] == mw[k]) begin
                    mcnt[k] = 0;
                    mle[k]  = 1;
                    mout[k] = 0;
                    // f = bit received i-th in time order within the frame
                    for (int i = 0; i < mw[k]; i++) begin
                        int f;
                        f = hist[k][mw[k]-1-i];
                        if (mmsb[k] != 0) mout[k] += f * (1 << (mw[k] - 1 - i));
                        else              mout[k] += f * (1 << i);
                    end
                end
            end else begin
                mle[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("a_out",   32'(out_a),   32'(mout[0]));
            check("a_le",    32'(le_a),    32'(mle[0]));
            check("a_count", 32'(count_a), 32'(mcnt[0]));
            check("a_sout",  32'(sout_a),  32'(hist[0][7]));
            check("b_out",   32'(out_b),   32'(mout[1]));
            check("b_le",    32'(le_b),    32'(mle[1]));
            check("b_count", 32'(count_b), 32'(mcnt[1]));
            check("b_sout",  32'(sout_b),  32'(hist[1][4]));
        end
    end

    // Drive one cycle's inputs at a falling edge and return at the next falling edge.
    task automatic cyc(input logic r, input logic c, input logic e, input logic s);
        rst = r; clr = c; en = e; sin = s;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] w;
        logic [4:0] pat;
        rst = 1'b1; clr = 1'b0; en = 1'b1; sin = 1'b1;
        @(negedge clk);

        // Reset held with en and sin high
        cyc(1, 0, 1, 1);
        chk_on = 1;
        cyc(1, 0, 1, 1);
        check("t1_out", 32'(out_a), 32'h00);
        check("t1_le", 32'(le_a), 0);
        check("t1_count", 32'(count_a), 0);
        check("t1_sout", 32'(sout_a), 0);

        // 0xA5 contiguous, MSB first
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            cyc(0, 0, 1, w[i]);
            if (i == 1) check("t2_out_before", 32'(out_a), 32'h00);
        end
        check("t2_out", 32'(out_a), 32'hA5);
        check("t2_le", 32'(le_a), 1);
        check("t2_count", 32'(count_a), 0);
        cyc(0, 0, 0, 0);
        check("t2_le_fall", 32'(le_a), 0);

        // 0xA5 with 3-cycle gaps after bits 2 and 5
        for (int i = 7; i >= 0; i--) begin
            cyc(0, 0, 1, w[i]);
            if (i == 6 || i == 3) begin
                for (int g = 0; g < 3; g++) cyc(0, 0, 0, ~w[i]);
                check("t3_count_hold", 32'(count_a), (i == 6) ? 2 : 5);
                check("t3_le_gap", 32'(le_a), 0);
            end
            if (i == 1) check("t3_le_early", 32'(le_a), 0);
        end
        check("t3_out", 32'(out_a), 32'hA5);
        check("t3_le", 32'(le_a), 1);
        cyc(0, 0, 0, 0);

        // 0x3C then 0xC3 back to back
        for (int j = 0; j < 16; j++) begin
            w = (j < 8) ? 8'h3C : 8'hC3;
            if (j >= 8) begin
                logic [7:0] prev;
                prev = 8'h3C;
                check("t4_sout", 32'(sout_a), 32'(prev[15-j]));
            end
            cyc(0, 0, 1, w[7 - (j % 8)]);
            check("t4_le", 32'(le_a), (j == 7 || j == 15) ? 1 : 0);
            if (j == 7)  check("t4_out1", 32'(out_a), 32'h3C);
            if (j == 15) check("t4_out2", 32'(out_a), 32'hC3);
        end

        // Partial frame, clr, then 0xFF
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1'($urandom_range(0, 1)));
        cyc(0, 1, 0, 0);
        check("t5_count_clr", 32'(count_a), 0);
        check("t5_out_kept", 32'(out_a), 32'hC3);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 1);
            if (i == 6) check("t5_out_before", 32'(out_a), 32'hC3);
        end
        check("t5_out_ff", 32'(out_a), 32'hFF);
        check("t5_le", 32'(le_a), 1);
        // clr coincident with the completing bit
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 0);
        check("t5_clr_le", 32'(le_a), 0);
        check("t5_clr_out", 32'(out_a), 32'hFF);
        check("t5_clr_count", 32'(count_a), 0);

        // LSB-first 5-bit instance
        cyc(1, 0, 0, 0);
        pat = 5'b11001;
        for (int i = 0; i < 5; i++) begin
            check("t6_count_seq", 32'(count_b), i);
            cyc(0, 0, 1, pat[i]);
        end
        check("t6_count_wrap", 32'(count_b), 0);
        check("t6_out", 32'(out_b), 32'h19);
        check("t6_le", 32'(le_b), 1);
        cyc(0, 0, 0, 0);
        check("t6_le_fall", 32'(le_b), 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(1, 0, 1, 1);
        check("t6_rst_out", 32'(out_b), 0);
        check("t6_rst_count", 32'(count_b), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)));
        end

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
